udp_frame_gen: RTL
==================

Name: udp_frame_gen

Overview:
Parametrised UDP/IPv4 test-frame generator feeding the MAC TX Avalon-ST interface (32-bit, big-endian, readyLatency 0).
- Sends one frame per period tick (when enabled) or per `start` pulse.
- Header fields (MAC/IP/port addresses) and payload length are set by parameters.
- The IPv4 header checksum is computed per frame, because the IP Identification field carries the frame counter.
- The payload is an incrementing byte pattern.

Parameters:
PERIOD_CYCLES, 50000000, clock cycles between automatic triggers (>=1)
PAYLOAD_BYTES, 18, UDP payload length in bytes, 18..1472 (keeps frame >=60 bytes excluding CRC)
IFG_CYCLES, 12, idle cycles forced after each frame's last beat
DST_MAC, 48'h0010A47BEA80, destination MAC
SRC_MAC, 48'h001234567890, source MAC
SRC_IP, 32'hC0A8002C, source IPv4
DST_IP, 32'hC0A80004, destination IPv4
SRC_PORT, 16'h0400, UDP source port
DST_PORT, 16'h0400, UDP destination port

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  enables periodic triggering
start  in  1  single-cycle manual trigger
tx_rdy  in  1  MAC ready; a beat transfers when tx_wren && tx_rdy
data_tx  out  32  frame word; [31:24] is the first byte on the wire
tx_mod  out  2  invalid byte count on the eop beat, 0 elsewhere
tx_sop  out  1  start of packet
tx_eop  out  1  end of packet
tx_err  out  1  tied 0
tx_wren  out  1  beat valid
tx_crc_fwd  out  1  tied 0 (MAC appends FCS)
busy  out  1  high in SEND and GAP
frame_cnt  out  16  frames completed, wraps at 0xFFFF

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, period counter 0, pending 0, frame_cnt 0. Reset mid-frame aborts the frame immediately; no eop is issued.
- Period counter: counts 0..PERIOD_CYCLES-1; tick is asserted on the terminal count.
- Trigger: pending is set by (tick && en) || start, and cleared on entry to SEND. At most one trigger is remembered during SEND/GAP; further triggers are dropped. Deasserting en mid-frame does not stop the frame.
- Frame length: L = 42 + PAYLOAD_BYTES bytes; W = ceil(L/4) beats; tx_mod on the eop beat = (4 - L%4)%4.
- Byte map:
  - 0-5 DST_MAC, 6-11 SRC_MAC, 12-13 0x0800.
  - 14-33 IPv4 header: 0x4500, total length = 28+PAYLOAD_BYTES, ID = frame_cnt, 0x0000, TTL 0x80 / protocol 0x11, checksum, SRC_IP, DST_IP.
  - 34-41 UDP header: SRC_PORT, DST_PORT, length = 8+PAYLOAD_BYTES, checksum 0x0000.
  - Payload byte k = k mod 256.
  - Pad bytes beyond L are 0x00.
- Checksum: one's-complement 16-bit sum of the header words (checksum field taken as 0), with two carry folds, then inverted. The constant part is folded at elaboration; ID is added at frame start and the result is registered before the first beat.
- FSM:
  - IDLE: tx_wren=0. When pending, load beat 0, assert tx_wren and tx_sop, go to SEND.
  - SEND: on each accepted beat advance the beat index. tx_sop is high only on beat 0; tx_eop and tx_mod are valid only on beat W-1.
  - On acceptance of beat W-1: drop tx_wren, increment frame_cnt, go to GAP.
  - GAP: count IFG_CYCLES, then go to IDLE.
- Backpressure: while tx_wren=1 and tx_rdy=0, data_tx, tx_sop, tx_eop and tx_mod are held stable.
- Latency: the first beat is presented 1 cycle after pending is observed in IDLE.

Optional Feature:
UDP_GEN_PREAMBLE_EN
- Defined: two extra beats, 0x55555555 then 0x555555D5, precede the header; tx_sop moves to the first preamble beat. W grows by 2; tx_mod is unchanged.
- Undefined: no preamble beats; the frame starts at DST_MAC.

Decomposition:
Shared package udp_gen_pkg holds:
- Constants: ETH_HDR_BYTES=14, IP_HDR_BYTES=20, UDP_HDR_BYTES=8, ETHERTYPE_IPV4, IP_PROTO_UDP, IP_TTL.
- State enum: IDLE, SEND, GAP.
- A checksum-fold function.

One sub-module, udp_hdr_rom: combinational byte-index-to-word mux over the header, checksum and payload pattern. The top level holds the FSM, counters and handshake.

Test Plan:
1. Defaults, no macro, tx_rdy=1, start pulse -> 15 beats, sop on beat 0, eop on beat 14 with tx_mod=0; beat0=0x0010A47B, beat6=0xB93EC0A8, beat10=0x00000001, beat14=0x0E0F1011; frame_cnt=1.
2. Second frame -> beat6=0xB93DC0A8 (ID=1); gap >=12 idle cycles between frames.
3. PAYLOAD_BYTES=19 -> 16 beats; eop beat=0x12000000 with tx_mod=3; total-length field 0x002F.
4. tx_rdy toggled randomly -> beat sequence identical to test 1; outputs stable whenever tx_rdy=0; no dropped or duplicated beats.
5. PERIOD_CYCLES=100, en=1, then en dropped mid-frame -> frame completes; no new frame starts; start pulses during SEND remember exactly one frame.
6. rst_n low at beat 7 -> all outputs 0 immediately; after release, the next start gives a fresh frame with ID=0. With UDP_GEN_PREAMBLE_EN defined: 17 beats, beat0=0x55555555 with sop.

Source files
------------

// File: rtl/udp_gen_pkg.sv
// Shared constants, FSM state type and checksum carry-fold helper for the
// UDP/IPv4 test-frame generator.
package udp_gen_pkg;

   localparam int ETH_HDR_BYTES = 14;
   localparam int IP_HDR_BYTES  = 20;
   localparam int UDP_HDR_BYTES = 8;

   localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
   localparam logic [15:0] IP_VER_IHL_TOS = 16'h4500;
   localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;
   localparam logic [7:0]  IP_TTL         = 8'h80;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      GAP  = 2'd2
   } gen_state_e;

   // Two end-around-carry folds bring any sum of up to 2^16 words into 16 bits.
   function automatic logic [15:0] csum_fold(input logic [31:0] sum);
      logic [31:0] s1;
      logic [31:0] s2;
      s1 = {16'h0000, sum[15:0]} + {16'h0000, sum[31:16]};
      s2 = {16'h0000, s1[15:0]} + {16'h0000, s1[31:16]};
      return s2[15:0];
   endfunction

endpackage

// File: rtl/udp_hdr_rom.sv
// Combinational beat-index-to-word mux over the Ethernet/IPv4/UDP header,
// the per-frame ID/checksum and the incrementing payload pattern.
module udp_hdr_rom
   import udp_gen_pkg::*;
#(
   parameter int          PAYLOAD_BYTES = 18,
   parameter logic [47:0] DST_MAC       = 48'h0010A47BEA80,
   parameter logic [47:0] SRC_MAC       = 48'h001234567890,
   parameter logic [31:0] SRC_IP        = 32'hC0A8002C,
   parameter logic [31:0] DST_IP        = 32'hC0A80004,
   parameter logic [15:0] SRC_PORT      = 16'h0400,
   parameter logic [15:0] DST_PORT      = 16'h0400
) (
   input  logic [15:0] beat_idx,
   input  logic [15:0] ip_id,
   input  logic [15:0] ip_csum,
   output logic [31:0] word_o
);

   localparam int          HDR_BYTES    = ETH_HDR_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES;
   localparam int          FRAME_BYTES  = HDR_BYTES + PAYLOAD_BYTES;
   localparam logic [15:0] IP_TOTAL_LEN = 16'(IP_HDR_BYTES + UDP_HDR_BYTES + PAYLOAD_BYTES);
   localparam logic [15:0] UDP_LEN      = 16'(UDP_HDR_BYTES + PAYLOAD_BYTES);

   function automatic logic [7:0] byte_at(input logic [31:0] idx,
                                          input logic [15:0] id,
                                          input logic [15:0] cs);
      logic [7:0] b;
      b = 8'h00;
      if (idx < 32'(HDR_BYTES)) begin
         case (idx[5:0])
            6'd0:    b = DST_MAC[47:40];
            6'd1:    b = DST_MAC[39:32];
            6'd2:    b = DST_MAC[31:24];
            6'd3:    b = DST_MAC[23:16];
            6'd4:    b = DST_MAC[15:8];
            6'd5:    b = DST_MAC[7:0];
            6'd6:    b = SRC_MAC[47:40];
            6'd7:    b = SRC_MAC[39:32];
            6'd8:    b = SRC_MAC[31:24];
            6'd9:    b = SRC_MAC[23:16];
            6'd10:   b = SRC_MAC[15:8];
            6'd11:   b = SRC_MAC[7:0];
            6'd12:   b = ETHERTYPE_IPV4[15:8];
            6'd13:   b = ETHERTYPE_IPV4[7:0];
            6'd14:   b = IP_VER_IHL_TOS[15:8];
            6'd15:   b = IP_VER_IHL_TOS[7:0];
            6'd16:   b = IP_TOTAL_LEN[15:8];
            6'd17:   b = IP_TOTAL_LEN[7:0];
            6'd18:   b = id[15:8];
            6'd19:   b = id[7:0];
            6'd22:   b = IP_TTL;
            6'd23:   b = IP_PROTO_UDP;
            6'd24:   b = cs[15:8];
            6'd25:   b = cs[7:0];
            6'd26:   b = SRC_IP[31:24];
            6'd27:   b = SRC_IP[23:16];
            6'd28:   b = SRC_IP[15:8];
            6'd29:   b = SRC_IP[7:0];
            6'd30:   b = DST_IP[31:24];
            6'd31:   b = DST_IP[23:16];
            6'd32:   b = DST_IP[15:8];
            6'd33:   b = DST_IP[7:0];
            6'd34:   b = SRC_PORT[15:8];
            6'd35:   b = SRC_PORT[7:0];
            6'd36:   b = DST_PORT[15:8];
            6'd37:   b = DST_PORT[7:0];
            6'd38:   b = UDP_LEN[15:8];
            6'd39:   b = UDP_LEN[7:0];
            default: b = 8'h00;
         endcase
      end else if (idx < 32'(FRAME_BYTES)) begin
         b = 8'(idx - 32'(HDR_BYTES));
      end else begin
         b = 8'h00;
      end
      return b;
   endfunction

   // Byte 0 of each beat lands in the most significant lane.
   always_comb begin
      word_o = 32'h0000_0000;
      for (int i = 0; i < 4; i++) begin
         word_o[8*(3-i) +: 8] = byte_at({14'd0, beat_idx, 2'b00} + 32'(i), ip_id, ip_csum);
      end
   end

endmodule

// File: rtl/udp_frame_gen.sv
// UDP/IPv4 test-frame generator for a 32-bit Avalon-ST MAC TX port.
// Define UDP_GEN_PREAMBLE_EN to prepend two preamble/SFD beats to each frame.
module udp_frame_gen
   import udp_gen_pkg::*;
#(
   parameter int          PERIOD_CYCLES = 50000000,
   parameter int          PAYLOAD_BYTES = 18,
   parameter int          IFG_CYCLES    = 12,
   parameter logic [47:0] DST_MAC       = 48'h0010A47BEA80,
   parameter logic [47:0] SRC_MAC       = 48'h001234567890,
   parameter logic [31:0] SRC_IP        = 32'hC0A8002C,
   parameter logic [31:0] DST_IP        = 32'hC0A80004,
   parameter logic [15:0] SRC_PORT      = 16'h0400,
   parameter logic [15:0] DST_PORT      = 16'h0400
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        start,
   input  logic        tx_rdy,
   output logic [31:0] data_tx,
   output logic [1:0]  tx_mod,
   output logic        tx_sop,
   output logic        tx_eop,
   output logic        tx_err,
   output logic        tx_wren,
   output logic        tx_crc_fwd,
   output logic        busy,
   output logic [15:0] frame_cnt
);

   localparam int FRAME_BYTES = ETH_HDR_BYTES + IP_HDR_BYTES + UDP_HDR_BYTES + PAYLOAD_BYTES;
   localparam int DATA_BEATS  = (FRAME_BYTES + 3) / 4;
`ifdef UDP_GEN_PREAMBLE_EN
   localparam int PRE_BEATS   = 2;
`else
   localparam int PRE_BEATS   = 0;
`endif
   localparam logic [15:0] LAST_BEAT    = 16'(DATA_BEATS + PRE_BEATS - 1);
   localparam logic [1:0]  EOP_MOD      = 2'((4 - (FRAME_BYTES % 4)) % 4);
   localparam logic [15:0] GAP_LAST     = 16'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
   localparam int          PCW          = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
   localparam logic [PCW-1:0] PCNT_LAST = PCW'(PERIOD_CYCLES - 1);
   localparam logic [15:0] IP_TOTAL_LEN = 16'(IP_HDR_BYTES + UDP_HDR_BYTES + PAYLOAD_BYTES);

   // Every header word except the ID, pre-folded so only the frame counter is added per frame.
   localparam logic [15:0] CSUM_BASE = csum_fold(32'(IP_VER_IHL_TOS) + 32'(IP_TOTAL_LEN)
                                                 + {16'h0000, IP_TTL, IP_PROTO_UDP}
                                                 + 32'(SRC_IP[31:16]) + 32'(SRC_IP[15:0])
                                                 + 32'(DST_IP[31:16]) + 32'(DST_IP[15:0]));

   gen_state_e     state_q, state_d;
   logic [15:0]    beat_q, beat_d;
   logic [15:0]    gap_q, gap_d;
   logic [PCW-1:0] pcnt_q, pcnt_d;
   logic           pend_q, pend_d;
   logic [15:0]    frame_cnt_q, frame_cnt_d;
   logic [15:0]    csum_q, csum_d;
   logic [31:0]    data_q, data_d;
   logic [1:0]     mod_q, mod_d;
   logic           sop_q, sop_d;
   logic           eop_q, eop_d;
   logic           wren_q, wren_d;
   logic           busy_q, busy_d;

   logic           tick_s;
   logic [15:0]    nxt_beat_s;
   logic [15:0]    rom_beat_s;
   logic [31:0]    rom_word_s;
   logic [31:0]    word_s;

   udp_hdr_rom #(
      .PAYLOAD_BYTES (PAYLOAD_BYTES),
      .DST_MAC       (DST_MAC),
      .SRC_MAC       (SRC_MAC),
      .SRC_IP        (SRC_IP),
      .DST_IP        (DST_IP),
      .SRC_PORT      (SRC_PORT),
      .DST_PORT      (DST_PORT)
   ) u_rom (
      .beat_idx (rom_beat_s),
      .ip_id    (frame_cnt_q),
      .ip_csum  (csum_q),
      .word_o   (rom_word_s)
   );

   // Period counter and the single-entry trigger latch.
   always_comb begin
      tick_s = (pcnt_q == PCNT_LAST);
      if (tick_s) begin
         pcnt_d = {PCW{1'b0}};
      end else begin
         pcnt_d = pcnt_q + PCW'(1);
      end
      pend_d = (pend_q && (state_q != IDLE)) || (tick_s && en) || start;
   end

   // Word for the beat that will be presented after the next edge.
   always_comb begin
      if (state_q == SEND) begin
         nxt_beat_s = beat_q + 16'd1;
      end else begin
         nxt_beat_s = 16'd0;
      end
`ifdef UDP_GEN_PREAMBLE_EN
      rom_beat_s = nxt_beat_s - 16'd2;
      if (nxt_beat_s == 16'd0) begin
         word_s = 32'h5555_5555;
      end else if (nxt_beat_s == 16'd1) begin
         word_s = 32'h5555_55D5;
      end else begin
         word_s = rom_word_s;
      end
`else
      rom_beat_s = nxt_beat_s;
      word_s     = rom_word_s;
`endif
   end

   // Frame FSM: next state and registered Avalon-ST outputs.
   always_comb begin
      state_d     = state_q;
      beat_d      = beat_q;
      gap_d       = gap_q;
      frame_cnt_d = frame_cnt_q;
      csum_d      = csum_q;
      data_d      = data_q;
      mod_d       = mod_q;
      sop_d       = sop_q;
      eop_d       = eop_q;
      wren_d      = wren_q;
      case (state_q)
         IDLE: begin
            if (pend_q) begin
               state_d = SEND;
               beat_d  = 16'd0;
               data_d  = word_s;
               wren_d  = 1'b1;
               sop_d   = 1'b1;
               eop_d   = (LAST_BEAT == 16'd0);
               mod_d   = (LAST_BEAT == 16'd0) ? EOP_MOD : 2'd0;
               csum_d  = ~csum_fold({16'h0000, CSUM_BASE} + {16'h0000, frame_cnt_q});
            end else begin
               data_d = 32'h0000_0000;
               wren_d = 1'b0;
               sop_d  = 1'b0;
               eop_d  = 1'b0;
               mod_d  = 2'd0;
            end
         end
         SEND: begin
            if (tx_rdy) begin
               if (beat_q == LAST_BEAT) begin
                  data_d      = 32'h0000_0000;
                  wren_d      = 1'b0;
                  sop_d       = 1'b0;
                  eop_d       = 1'b0;
                  mod_d       = 2'd0;
                  frame_cnt_d = frame_cnt_q + 16'd1;
                  gap_d       = 16'd0;
                  state_d     = (IFG_CYCLES > 0) ? GAP : IDLE;
               end else begin
                  beat_d = nxt_beat_s;
                  data_d = word_s;
                  sop_d  = 1'b0;
                  eop_d  = (nxt_beat_s == LAST_BEAT);
                  mod_d  = (nxt_beat_s == LAST_BEAT) ? EOP_MOD : 2'd0;
               end
            end else begin
               state_d = SEND;
            end
         end
         GAP: begin
            if (gap_q == GAP_LAST) begin
               state_d = IDLE;
            end else begin
               gap_d = gap_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
            data_d  = 32'h0000_0000;
            wren_d  = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            mod_d   = 2'd0;
         end
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         beat_q      <= 16'd0;
         gap_q       <= 16'd0;
         pcnt_q      <= {PCW{1'b0}};
         pend_q      <= 1'b0;
         frame_cnt_q <= 16'd0;
         csum_q      <= 16'd0;
         data_q      <= 32'h0000_0000;
         mod_q       <= 2'd0;
         sop_q       <= 1'b0;
         eop_q       <= 1'b0;
         wren_q      <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         beat_q      <= beat_d;
         gap_q       <= gap_d;
         pcnt_q      <= pcnt_d;
         pend_q      <= pend_d;
         frame_cnt_q <= frame_cnt_d;
         csum_q      <= csum_d;
         data_q      <= data_d;
         mod_q       <= mod_d;
         sop_q       <= sop_d;
         eop_q       <= eop_d;
         wren_q      <= wren_d;
         busy_q      <= busy_d;
      end
   end

   assign data_tx    = data_q;
   assign tx_mod     = mod_q;
   assign tx_sop     = sop_q;
   assign tx_eop     = eop_q;
   assign tx_err     = 1'b0;
   assign tx_wren    = wren_q;
   assign tx_crc_fwd = 1'b0;
   assign busy       = busy_q;
   assign frame_cnt  = frame_cnt_q;

endmodule
